// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter with bounded burst hold in front of a single-port synchronous memory.
// Define MEM_ARBITER_STATS_EN to add grant and stall counters.
module mem_arbiter #(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]       m0_gnt_cnt,
    output logic [31:0]       m1_gnt_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int RUN_W = $clog2(BURST_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST_MAX);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic             last;
    logic [RUN_W-1:0] run;
    logic             rd_pend;
    logic             rd_owner;
    logic             any_gnt;
    logic             win;
    logic             sel_we;

    always_comb begin
        any_gnt = 1'b0;
        win     = last;
        if (!rst) begin
            if (m0_req && m1_req) begin
                any_gnt = 1'b1;
                win     = (run == RUN_MAX) ? ~last : last;
            end else if (m0_req || m1_req) begin
                any_gnt = 1'b1;
                win     = m1_req;
            end
        end
    end

    always_comb begin
        m0_gnt    = any_gnt & ~win;
        m1_gnt    = any_gnt & win;
        sel_we    = win ? m1_we : m0_we;
        mem_re    = any_gnt & ~sel_we;
        mem_we    = any_gnt & sel_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_gnt) begin
            mem_addr  = win ? m1_addr  : m0_addr;
            mem_wdata = win ? m1_wdata : m0_wdata;
        end
    end

    // The holder resets to m0: the first contention after reset goes to m0,
    // and contention after an idle gap stays with whoever won last.
    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 1'b0;
            run      <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (any_gnt) begin
                if (win == last) begin
                    if (run != RUN_MAX) run <= run + RUN_ONE;
                end else begin
                    last <= win;
                    run  <= RUN_ONE;
                end
            end else begin
                run <= '0;
            end
            rd_pend  <= mem_re;
            rd_owner <= win;
        end
    end

    always_comb begin
        m0_rvalid = rd_pend & ~rd_owner & ~rst;
        m1_rvalid = rd_pend & rd_owner & ~rst;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_gnt_cnt <= '0;
            m1_gnt_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            m0_gnt_cnt <= m0_gnt_cnt + 32'(m0_gnt);
            m1_gnt_cnt <= m1_gnt_cnt + 32'(m1_gnt);
            stall_cnt  <= stall_cnt + 32'(m0_req & ~m0_gnt) + 32'(m1_req & ~m1_gnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants and
// read returns; a negedge monitor pops and compares. Honors MEM_ARBITER_STATS_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0]   m0_gnt_cnt, m1_gnt_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARBITER_STATS_EN
        , .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt), .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0DE00, a};
    endfunction

    // Memory environment, aliased on the low 8 address bits.
    bit [31:0] env_mem [256];
    bit        env_wr  [256];
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);
        if (mem_we) begin
            env_mem[mem_addr[7:0]] <= mem_wdata;
            env_wr[mem_addr[7:0]]  <= 1'b1;
        end
    end

    typedef struct { int due; logic [65:0] v; } ret_t;

    logic [31:0] ref_mem [256];
    logic [65:0] gq[$];
    ret_t        rq[$];
    int          obs_w[int];
    int          exp_seq[$];
    int          holder = 0, streak = 0, cyc = 0, last_w = -1;
    int unsigned cnt0 = 0, cnt1 = 0, cnts = 0;
    int unsigned snap0 = 0, snap1 = 0, snaps = 0;
    int          checks = 0, failures = 0;
    bit          done0 = 1'b0, done1 = 1'b0;

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Model: the holder keeps winning contention until it has BM consecutive wins.
    task automatic commit();
        int w;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rv;
        ret_t r;
        snap0 = cnt0; snap1 = cnt1; snaps = cnts;
        last_w = -1;
        if (rst) begin
            while (rq.size() > 0 && rq[$].due == cyc) void'(rq.pop_back());
            holder = 0; streak = 0; cnt0 = 0; cnt1 = 0; cnts = 0;
            gq.push_back('0);
            return;
        end
        w = -1;
        if (m0_req && m1_req) w = (streak >= BM) ? 1 - holder : holder;
        else if (m0_req) w = 0;
        else if (m1_req) w = 1;
        if (w < 0) begin
            streak = 0;
            gq.push_back('0);
        end else begin
            we = (w == 1) ? m1_we : m0_we;
            a  = (w == 1) ? m1_addr : m0_addr;
            d  = (w == 1) ? m1_wdata : m0_wdata;
            gq.push_back({(w == 0), (w == 1), ~we, we, a, d});
            if (we) ref_mem[a[7:0]] = d;
            else begin
                rv = ref_mem[a[7:0]];
                r.due = cyc + 1;
                r.v = (w == 0) ? {2'b10, rv, 32'h0} : {2'b01, 32'h0, rv};
                rq.push_back(r);
            end
            if (w == holder) streak++;
            else begin holder = w; streak = 1; end
            if (w == 0) cnt0++; else cnt1++;
        end
        cnts += ((m0_req && w != 0) ? 1 : 0) + ((m1_req && w != 1) ? 1 : 0);
        last_w = w;
    endtask

    initial begin
        forever begin
            logic [65:0] e, a;
            @(negedge clk);
            if (gq.size() > 0) begin
                e = gq.pop_front();
                a = {m0_gnt, m1_gnt, mem_re, mem_we, mem_addr, mem_wdata};
                check("grant", a, e);
                obs_w[cyc] = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
                e = '0;
                if (rq.size() > 0 && rq[0].due == cyc) e = rq.pop_front().v;
                check("rdata", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, e);
`ifdef MEM_ARBITER_STATS_EN
                check("m0_gnt_cnt", {34'b0, m0_gnt_cnt}, {34'b0, snap0});
                check("m1_gnt_cnt", {34'b0, m1_gnt_cnt}, {34'b0, snap1});
                check("stall_cnt",  {34'b0, stall_cnt},  {34'b0, snaps});
`endif
            end
        end
    end

    task automatic set_m(input int k, input logic q, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (k == 0) begin m0_req = q; m0_we = w; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = q; m1_we = w; m1_addr = a; m1_wdata = d; end
    endtask

    task automatic roll(input int k, input int p_req, input int p_we);
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[7:0] = 8'($urandom_range(31));
        set_m(k, ($urandom_range(99) < p_req), ($urandom_range(99) < p_we), a, $urandom);
    endtask

    task automatic begin_cycle(input logic r);
        @(posedge clk); #1;
        cyc++;
        rst = r;
    endtask

    task automatic end_cycle();
        commit();
        done0 = (last_w == 0);
        done1 = (last_w == 1);
    endtask

    task automatic auto_cycle(input logic r, input int p0, input int p1, input int pw);
        begin_cycle(r);
        if (done0 || !m0_req) roll(0, p0, pw);
        if (done1 || !m1_req) roll(1, p1, pw);
        end_cycle();
    endtask

    task automatic idle_cycle(input logic r);
        begin_cycle(r);
        set_m(0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        end_cycle();
    endtask

    task automatic check_seq(input int start);
        @(negedge clk); #1;
        foreach (exp_seq[i]) begin
            int got;
            got = obs_w.exists(start + i) ? obs_w[start + i] : -2;
            checks++;
            if (got != exp_seq[i]) begin
                failures++;
                $display("FAIL winner_seq idx=%0d got=%0d exp=%0d", i, got, exp_seq[i]);
            end
        end
    endtask

    initial begin
        int start;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

        // Reset, then contention from reset: m0 x4, m1 x4, m0 x4.
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        start = cyc + 1;
        for (int i = 0; i < 12; i++) auto_cycle(1'b0, 100, 100, 0);
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        check_seq(start);

        // Single master read of 0x10.
        idle_cycle(1'b0);
        begin_cycle(1'b0);
        set_m(0, 1'b1, 1'b0, 30'h10, '0);
        end_cycle();
        idle_cycle(1'b0);

        // m1 writes 0x20, then m0 reads it back.
        begin_cycle(1'b0);
        set_m(1, 1'b1, 1'b1, 30'h20, 32'h12345678);
        end_cycle();
        begin_cycle(1'b0);
        set_m(1, 1'b0, 1'b0, '0, '0);
        set_m(0, 1'b1, 1'b0, 30'h20, '0);
        end_cycle();
        idle_cycle(1'b0);

        // Idle gap: m0 wins two, one idle cycle, then contention stays with m0 for four.
        for (int i = 0; i < 2; i++) auto_cycle(1'b0, 100, 0, 0);
        idle_cycle(1'b0);
        start = cyc + 1;
        for (int i = 0; i < 6; i++) auto_cycle(1'b0, 100, 100, 0);
        exp_seq = '{0, 0, 0, 0, 1, 1};
        check_seq(start);

        // Reset the cycle after an m1 read grant, and with a request held during reset.
        idle_cycle(1'b0);
        begin_cycle(1'b0);
        set_m(1, 1'b1, 1'b0, 30'h5, '0);
        end_cycle();
        begin_cycle(1'b1);
        set_m(1, 1'b1, 1'b0, 30'h6, '0);
        end_cycle();
        start = cyc + 1;
        for (int i = 0; i < 3; i++) auto_cycle(1'b0, 100, 100, 0);
        exp_seq = '{0, 0, 0};
        check_seq(start);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++)
            auto_cycle(($urandom_range(79) == 0), 60, 60, 35);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        @(negedge clk); #1;
        check("rq_drained", 66'(rq.size()), 66'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
